// File: rtl/prime_detect_scheduler.sv
// prime_detect_scheduler: round-robin front end for the bit-serial 8-bit prime detector.
// It grants one requester at a time, loads the operand into the detector, waits up to TIMEOUT RUN cycles
// for a verdict, then holds a tagged response. The verdict is forced to not-prime for operands 0 and 1.
// Ports: req_valid/req_number/req_ready are the requester side; req_ready is a one-hot accept strobe.
//        det_* drive the detector and return its verdict.
//        rsp_valid/rsp_ready plus rsp_id/rsp_number/rsp_prime/rsp_gt20/rsp_err carry the response.
//        busy is high whenever the FSM is not in IDLE.
module prime_detect_scheduler #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_number,
   output logic [NREQ-1:0]   req_ready,
   output logic              det_reset,
   output logic [7:0]        det_number,
   input  logic              det_prime,
   input  logic              det_not_prime,
   input  logic              det_gt20,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_number,
   output logic              rsp_prime,
   output logic              rsp_gt20,
   output logic              rsp_err,
   output logic              busy
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t          state;
   state_t          state_nx;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  id_q;
   logic [7:0]      num_q;
   logic [CW-1:0]   cnt;
   logic            prime_q;
   logic            gt20_q;
   logic            err_q;

   logic            grant_any;
   logic [IDW-1:0]  win;
   logic [IDW-1:0]  cand;
   logic            verdict;
   logic            timeout;

   // Both verdict lines high counts as a verdict but resolves to not-prime.
   assign verdict = det_prime | det_not_prime;
   assign timeout = (cnt == CW'(TIMEOUT - 1));

   // Round-robin search: first valid requester at or after ptr, wrapping.
   always_comb begin : arb
      grant_any = 1'b0;
      win       = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = IDW'((int'(ptr) + i) % NREQ);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            win       = cand;
         end
      end
   end

   always_ff @(posedge clk) begin : state_reg
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin : fsm
      state_nx  = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            // Gated with reset so no grant strobe is shown while reset is held.
            if (grant_any && !reset) begin
               req_ready[win] = 1'b1;
               state_nx       = LOAD;
            end
         end
         LOAD: state_nx = RUN;
         RUN:  if (verdict || timeout) state_nx = RESP;
         RESP: if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin : datapath
      if (reset) begin
         ptr     <= '0;
         id_q    <= '0;
         num_q   <= '0;
         cnt     <= '0;
         prime_q <= 1'b0;
         gt20_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  num_q <= req_number[{win, 3'b000} +: 8];
                  id_q  <= win;
                  ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
               end
            end
            LOAD: cnt <= '0;
            RUN: begin
               cnt <= cnt + 1'b1;
               // Verdict is checked first so it wins over a same-cycle timeout.
               if (verdict) begin
                  prime_q <= det_prime & ~det_not_prime & (num_q > 8'd1);
                  gt20_q  <= det_gt20;
                  err_q   <= 1'b0;
               end else if (timeout) begin
                  prime_q <= 1'b0;
                  gt20_q  <= det_gt20;
                  err_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign det_reset  = (state != RUN);
   assign det_number = num_q;
   assign rsp_valid  = (state == RESP);
   assign rsp_id     = id_q;
   assign rsp_number = num_q;
   assign rsp_prime  = prime_q;
   assign rsp_gt20   = gt20_q;
   assign rsp_err    = err_q;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_prime_detect_scheduler.sv
// tb_prime_detect_scheduler: randomized bench for prime_detect_scheduler with a behavioural detector stub.
// Expected grants, latencies and verdicts come from arithmetic primality and round-robin rules.
// Ports: none (top-level bench).
module tb_prime_detect_scheduler;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 16;
   localparam int M_NORM  = 0;
   localparam int M_HANG  = 1;
   localparam int M_BOTH  = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_number;
   logic [NREQ-1:0]   req_ready;
   logic              det_reset;
   logic [7:0]        det_number;
   logic              det_prime;
   logic              det_not_prime;
   logic              det_gt20;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        rsp_number;
   logic              rsp_prime;
   logic              rsp_gt20;
   logic              rsp_err;
   logic              busy;

   int total = 0;
   int bad   = 0;
   int mptr  = 0;
   int mode  = M_NORM;
   int dly   = 7;
   int dcnt  = 0;

   prime_detect_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_number(req_number),
      .req_ready(req_ready), .det_reset(det_reset), .det_number(det_number),
      .det_prime(det_prime), .det_not_prime(det_not_prime), .det_gt20(det_gt20),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_number(rsp_number), .rsp_prime(rsp_prime), .rsp_gt20(rsp_gt20),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // True primality by exhaustive trial division.
   function automatic bit is_prime(input int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d < n; d++) if (n % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   // What the hardware detector reports: trial divisors 2..13 only (wrong for 0 and 1).
   function automatic bit raw_det(input int n);
      for (int d = 2; d <= 13; d++) if (d < n && n % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   // Detector stub: verdict appears in RUN cycle dly+1 after det_reset drops.
   always @(posedge clk) begin
      if (det_reset) dcnt <= 0;
      else           dcnt <= dcnt + 1;
   end

   always_comb begin
      det_prime     = 1'b0;
      det_not_prime = 1'b0;
      det_gt20      = 1'b0;
      if (!det_reset && mode != M_HANG) begin
         det_gt20 = (det_number > 8'd20);
         if (dcnt == dly) begin
            if (mode == M_BOTH) begin
               det_prime     = 1'b1;
               det_not_prime = 1'b1;
            end else begin
               det_prime     = raw_det(int'(det_number));
               det_not_prime = !raw_det(int'(det_number));
            end
         end
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_req(input int p, input int n);
      req_valid[p]          = 1'b1;
      req_number[p*8 +: 8]  = 8'(n);
   endtask

   task automatic check_reset();
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_det_reset", int'(det_reset), 1);
      chk("rst_det_number", int'(det_number), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_rsp_number", int'(rsp_number), 0);
      chk("rst_rsp_prime", int'(rsp_prime), 0);
      chk("rst_rsp_gt20", int'(rsp_gt20), 0);
      chk("rst_rsp_err", int'(rsp_err), 0);
      chk("rst_busy", int'(busy), 0);
   endtask

   function automatic int exp_winner();
      for (int i = 0; i < NREQ; i++)
         if (req_valid[(mptr + i) % NREQ]) return (mptr + i) % NREQ;
      return -1;
   endfunction

   // Called at a negedge with requests already driven; returns after the accept edge, at the next negedge.
   task automatic grant_wait(output int w, output int num);
      int n  = 0;
      int ew = exp_winner();
      #1;
      while (req_ready == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("grant_delay", n, 0);
      chk("grant_onehot", int'(req_ready), (ew < 0) ? 0 : (1 << ew));
      if (ew < 0) begin
         $display("FAIL no_request: got none expected a pending request");
         $fatal(1, "no request pending");
      end
      w    = ew;
      num  = int'(req_number[ew*8 +: 8]);
      mptr = (ew + 1) % NREQ;
      @(posedge clk);
      #1 req_valid[ew] = 1'b0;
      @(negedge clk);
      chk("load_det_number", int'(det_number), num);
      chk("load_busy", int'(busy), 1);
   endtask

   task automatic chk_rsp(input int w, input int num, input int ep, input int eg, input int ee);
      chk("rsp_valid", int'(rsp_valid), 1);
      chk("rsp_id", int'(rsp_id), w);
      chk("rsp_number", int'(rsp_number), num);
      chk("rsp_prime", int'(rsp_prime), ep);
      chk("rsp_gt20", int'(rsp_gt20), eg);
      chk("rsp_err", int'(rsp_err), ee);
   endtask

   task automatic finish_op(input int w, input int num, input int stall);
      int n   = 1;
      int ee  = (mode == M_HANG || dly > TIMEOUT - 1) ? 1 : 0;
      int ep  = (ee == 0 && mode == M_NORM && is_prime(num)) ? 1 : 0;
      int eg  = (mode == M_HANG) ? 0 : ((num > 20) ? 1 : 0);
      int lat = ee ? TIMEOUT + 2 : dly + 3;
      while (!rsp_valid && n < 60) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk("latency", n, lat);
      chk_rsp(w, num, ep, eg, ee);
      chk("resp_det_reset", int'(det_reset), 1);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         @(negedge clk);
         chk_rsp(w, num, ep, eg, ee);
         chk("stall_req_ready", int'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("after_acc_valid", int'(rsp_valid), 0);
      chk("after_acc_busy", int'(busy), 0);
   endtask

   task automatic run_op(input int stall);
      int w;
      int num;
      grant_wait(w, num);
      finish_op(w, num, stall);
   endtask

   initial begin
      int w;
      int num;
      bit seen;
      reset      = 1'b1;
      req_valid  = '0;
      req_number = '0;
      rsp_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset();
      // A request held during reset must not be strobed.
      set_req(0, 13);
      #1 chk("rst_gate_ready", int'(req_ready), 0);
      @(negedge clk);
      reset = 1'b0;
      run_op(0);

      // Simultaneous 221 and 251, then later arrivals queue behind the pointer.
      set_req(1, 221);
      set_req(3, 251);
      run_op(0);
      set_req(1, 9);
      set_req(2, 4);
      run_op(0);
      run_op(0);
      run_op(0);

      // Operands 0, 1, 2 back to back on port 0.
      for (int k = 0; k < 3; k++) begin
         set_req(0, k);
         run_op(0);
      end

      // Stalled response with another request pending.
      set_req(1, 97);
      set_req(2, 25);
      run_op(5);
      run_op(0);

      // Hung detector, then normal recovery.
      mode = M_HANG;
      set_req(3, 200);
      run_op(1);
      mode = M_NORM;
      set_req(0, 7);
      run_op(0);

      // Conflicting verdict lines, and verdict/timeout boundary.
      mode = M_BOTH;
      set_req(1, 11);
      run_op(0);
      mode = M_NORM;
      dly  = TIMEOUT - 1;
      set_req(2, 23);
      run_op(0);
      dly  = TIMEOUT;
      set_req(3, 30);
      run_op(0);
      dly  = 7;

      // Reset in the 4th RUN cycle: operation discarded, pointer back to 0.
      set_req(2, 50);
      grant_wait(w, num);
      repeat (4) @(negedge clk);
      chk("run_det_reset", int'(det_reset), 0);
      reset = 1'b1;
      @(negedge clk);
      check_reset();
      mptr  = 0;
      reset = 1'b0;
      seen  = 1'b0;
      repeat (14) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("no_rsp_after_reset", int'(seen), 0);
      set_req(1, 61);
      set_req(3, 62);
      run_op(0);
      chk("ptr_after_reset", mptr, 2);
      run_op(0);

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         int r;
         for (int p = 0; p < NREQ; p++) begin
            if (!req_valid[p] && $urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 3) == 0) set_req(p, int'($urandom_range(0, 3)));
               else                           set_req(p, int'($urandom_range(0, 255)));
            end
         end
         if (req_valid == '0) set_req(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 255)));
         r    = int'($urandom_range(0, 9));
         mode = (r == 0) ? M_HANG : (r == 1) ? M_BOTH : M_NORM;
         dly  = ($urandom_range(0, 9) < 7) ? 7 : int'($urandom_range(0, 20));
         run_op(int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
